// File: rtl/core_btb_pkg.sv
// Shared BTB definitions: controller state encoding, index/tag geometry,
// the queued update entry layout and the PC tag-fold function.
package core_btb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } btb_state_e;

   localparam int BTB_IDX_W  = 6;
   localparam int BTB_TAG_W  = 11;
   localparam int BTB_TGT_W  = 30;
   localparam int BTB_TYPE_W = 2;

   typedef struct packed {
      logic [BTB_IDX_W-1:0]  idx;
      logic [BTB_TAG_W-1:0]  tag;
      logic [BTB_TGT_W-1:0]  tgt;
      logic [BTB_TYPE_W-1:0] typ;
   } btb_entry_t;

   // pc_hi is pc[29:8]; tag bit k folds the adjacent pair pc[2k+9]^pc[2k+8].
   function automatic logic [BTB_TAG_W-1:0] btb_tag_fold(input logic [2*BTB_TAG_W-1:0] pc_hi);
      logic [BTB_TAG_W-1:0] tag;
      for (int k = 0; k < BTB_TAG_W; k++) begin
         tag[k] = pc_hi[2*k+1] ^ pc_hi[2*k];
      end
      return tag;
   endfunction

endpackage

// File: rtl/core_btb_upd_fifo.sv
// Small circular update queue with push/pop/clear; pointers wrap modulo DEPTH.
// A push while full is dropped: there is no same-cycle pop bypass.
module core_btb_upd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign rd_data = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is pure datapath; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/core_btb_ctrl.sv
// BTB write controller: queues taken branch updates and drains one per cycle
// into the BTB, or walks every entry writing zeros when a flush is requested.
module core_btb_ctrl
   import core_btb_pkg::*;
#(
   parameter int QDEPTH    = 4,
   parameter int BTB_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic [1:0]  upd_type,
   input  logic        upd_taken,
   input  logic        flush_req,
   output logic        flush_busy,
   output logic        btb_wr_en,
   output logic [5:0]  btb_wr_index,
   output logic [10:0] btb_wr_tag,
   output logic [31:0] btb_wr_target,
   output logic [1:0]  btb_wr_type,
   output logic        pred_block
);

   localparam logic [BTB_IDX_W-1:0] LAST_IDX = BTB_IDX_W'(BTB_DEPTH - 1);

   btb_state_e           state_q, state_d;
   logic [BTB_IDX_W-1:0] flush_idx_q, flush_idx_d;
   btb_entry_t           push_entry, head_entry;
   logic                 q_push, q_pop, q_clear, q_full, q_empty;
   logic                 unused_bits;

   // Handshake: an update transfers on any rising edge with upd_valid and
   // upd_ready both high; not-taken updates transfer but are not queued.
   assign q_push = upd_valid & upd_ready & upd_taken;

   assign push_entry.idx = upd_pc[7:2];
   assign push_entry.tag = btb_tag_fold(upd_pc[29:8]);
   assign push_entry.tgt = upd_target[31:2];
   assign push_entry.typ = upd_type;

   assign unused_bits = ^{upd_pc[31:30], upd_pc[1:0], upd_target[1:0]};

   assign flush_busy = (state_q == ST_FLUSH);
   assign pred_block = (state_q == ST_FLUSH);

   core_btb_upd_fifo #(
      .DEPTH (QDEPTH),
      .W     ($bits(btb_entry_t))
   ) u_upd_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (q_push),
      .pop     (q_pop),
      .clear   (q_clear),
      .wr_data (push_entry),
      .rd_data (head_entry),
      .full    (q_full),
      .empty   (q_empty)
   );

   always_comb begin
      state_d       = state_q;
      flush_idx_d   = flush_idx_q;
      upd_ready     = 1'b0;
      q_pop         = 1'b0;
      q_clear       = 1'b0;
      btb_wr_en     = 1'b0;
      btb_wr_index  = '0;
      btb_wr_tag    = '0;
      btb_wr_target = '0;
      btb_wr_type   = '0;
      case (state_q)
         ST_IDLE: begin
            upd_ready = ~q_full & ~flush_req;
            if (flush_req) begin
               // Queued updates are stale once the whole BTB is wiped.
               state_d     = ST_FLUSH;
               flush_idx_d = '0;
               q_clear     = 1'b1;
            end else if (!q_empty) begin
               q_pop         = 1'b1;
               btb_wr_en     = 1'b1;
               btb_wr_index  = head_entry.idx;
               btb_wr_tag    = head_entry.tag;
               btb_wr_target = {head_entry.tgt, 2'b00};
               btb_wr_type   = head_entry.typ;
            end
         end
         ST_FLUSH: begin
            btb_wr_en    = 1'b1;
            btb_wr_index = flush_idx_q;
            if (flush_idx_q == LAST_IDX) begin
               state_d     = ST_IDLE;
               flush_idx_d = '0;
            end else begin
               flush_idx_d = flush_idx_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         flush_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_idx_q <= flush_idx_d;
      end
   end

endmodule
